// File: rtl/rto_pkg.sv
// Shared types and default widths for the timestamped real-time output core.
// Also holds the saturating increment used by the late counter.
package rto_pkg;

  typedef enum logic {
    LATE_DROP = 1'b0,
    LATE_EMIT = 1'b1
  } late_mode_e;

  localparam int RTO_DATA_W = 128;
  localparam int RTO_TS_W   = 64;
  localparam int RTO_TS_LSB = 32;
  localparam int LATE_CNT_W = 16;

  function automatic logic [LATE_CNT_W-1:0] sat_inc(input logic [LATE_CNT_W-1:0] v);
    return (&v) ? v : v + LATE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rto_sync_fifo.sv
// First-word-fall-through synchronous FIFO with one-cycle flush.
// Pointers carry one extra bit so full and empty differ only in the MSB.
module rto_sync_fifo
  import rto_pkg::*;
#(
  parameter int WIDTH = RTO_DATA_W,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign wr_ok   = wr_en & ~full & ~flush;
  assign rd_ok   = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rto_core_param.sv
// Timestamped real-time output core: releases the FIFO head when the global
// counter reaches its timestamp, and flags entries that arrive too late.
module rto_core_param
  import rto_pkg::*;
#(
  parameter int DATA_W    = RTO_DATA_W,
  parameter int TS_W      = RTO_TS_W,
  parameter int TS_LSB    = RTO_TS_LSB,
  parameter int DEPTH     = 512,
  parameter int LATE_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    auto_start,
  input  logic                    flush,
  input  logic                    write,
  input  logic [DATA_W-1:0]       din,
  input  logic [TS_W-1:0]         counter,
  input  logic                    error_clear,
  output logic [DATA_W-1:0]       rto_out,
  output logic                    rto_valid,
  output logic                    timestamp_error,
  output logic [DATA_W-1:0]       timestamp_error_data,
  output logic                    overflow_error,
  output logic [DATA_W-1:0]       overflow_error_data,
  output logic                    ts_err_sticky,
  output logic                    ovf_err_sticky,
  output logic [LATE_CNT_W-1:0]   late_count,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam bit EMIT_LATE = (LATE_MODE == int'(LATE_EMIT));

  logic [DATA_W-1:0] head;
  logic [TS_W-1:0]   head_ts;
  logic              match;
  logic              late;
  logic              pop;
  logic              ovf;

  logic [DATA_W-1:0]     rto_out_q, rto_out_d;
  logic                  rto_valid_q, rto_valid_d;
  logic                  ts_err_q, ts_err_d;
  logic [DATA_W-1:0]     ts_err_data_q, ts_err_data_d;
  logic                  ovf_err_q, ovf_err_d;
  logic [DATA_W-1:0]     ovf_err_data_q, ovf_err_data_d;
  logic                  ts_sticky_q, ts_sticky_d;
  logic                  ovf_sticky_q, ovf_sticky_d;
  logic [LATE_CNT_W-1:0] late_cnt_q, late_cnt_d;

  rto_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (write),
    .wr_data (din),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign head_ts = head[TS_LSB +: TS_W];
  assign match   = auto_start & ~empty & (counter == head_ts);
  assign late    = auto_start & ~empty & (counter > head_ts);
  assign pop     = match | late;
  // A flush swallows a concurrent write silently, so it never counts as overflow.
  assign ovf     = write & full & ~flush;

  always_comb begin
    rto_out_d      = rto_out_q;
    rto_valid_d    = 1'b0;
    ts_err_d       = 1'b0;
    ts_err_data_d  = ts_err_data_q;
    ovf_err_d      = 1'b0;
    ovf_err_data_d = ovf_err_data_q;
    ts_sticky_d    = error_clear ? 1'b0 : ts_sticky_q;
    ovf_sticky_d   = error_clear ? 1'b0 : ovf_sticky_q;
    late_cnt_d     = error_clear ? '0 : late_cnt_q;

    if (match || (late && EMIT_LATE)) begin
      rto_out_d   = head;
      rto_valid_d = 1'b1;
    end

    // Error events are applied after the clear so they win in the same cycle.
    if (late) begin
      ts_err_d      = 1'b1;
      ts_err_data_d = head;
      ts_sticky_d   = 1'b1;
      late_cnt_d    = sat_inc(late_cnt_d);
    end

    if (ovf) begin
      ovf_err_d      = 1'b1;
      ovf_err_data_d = din;
      ovf_sticky_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rto_out_q      <= '0;
      rto_valid_q    <= 1'b0;
      ts_err_q       <= 1'b0;
      ts_err_data_q  <= '0;
      ovf_err_q      <= 1'b0;
      ovf_err_data_q <= '0;
      ts_sticky_q    <= 1'b0;
      ovf_sticky_q   <= 1'b0;
      late_cnt_q     <= '0;
    end else begin
      rto_out_q      <= rto_out_d;
      rto_valid_q    <= rto_valid_d;
      ts_err_q       <= ts_err_d;
      ts_err_data_q  <= ts_err_data_d;
      ovf_err_q      <= ovf_err_d;
      ovf_err_data_q <= ovf_err_data_d;
      ts_sticky_q    <= ts_sticky_d;
      ovf_sticky_q   <= ovf_sticky_d;
      late_cnt_q     <= late_cnt_d;
    end
  end

  assign rto_out              = rto_out_q;
  assign rto_valid            = rto_valid_q;
  assign timestamp_error      = ts_err_q;
  assign timestamp_error_data = ts_err_data_q;
  assign overflow_error       = ovf_err_q;
  assign overflow_error_data  = ovf_err_data_q;
  assign ts_err_sticky        = ts_sticky_q;
  assign ovf_err_sticky       = ovf_sticky_q;
  assign late_count           = late_cnt_q;

endmodule

// File: tb/tb_rto_core_param.sv
// Directed bench for rto_core_param: one DROP and one EMIT instance share stimulus.
module tb_rto_core_param;

  localparam int DW = 40;
  localparam int TW = 16;
  localparam int TL = 8;
  localparam int DP = 4;
  localparam int LW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          auto_start;
  logic          flush;
  logic          write;
  logic [DW-1:0] din;
  logic [TW-1:0] counter;
  logic          error_clear;

  logic [DW-1:0] d_rto_out, d_ts_data, d_ovf_data;
  logic          d_valid, d_ts_err, d_ovf_err, d_ts_sticky, d_ovf_sticky, d_full, d_empty;
  logic [15:0]   d_late_cnt;
  logic [LW-1:0] d_level;

  logic [DW-1:0] e_rto_out, e_ts_data, e_ovf_data;
  logic          e_valid, e_ts_err, e_ovf_err, e_ts_sticky, e_ovf_sticky, e_full, e_empty;
  logic [15:0]   e_late_cnt;
  logic [LW-1:0] e_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rto_core_param #(.DATA_W(DW), .TS_W(TW), .TS_LSB(TL), .DEPTH(DP), .LATE_MODE(0)) u_drop (
    .clk(clk), .reset(reset), .auto_start(auto_start), .flush(flush), .write(write),
    .din(din), .counter(counter), .error_clear(error_clear),
    .rto_out(d_rto_out), .rto_valid(d_valid), .timestamp_error(d_ts_err),
    .timestamp_error_data(d_ts_data), .overflow_error(d_ovf_err),
    .overflow_error_data(d_ovf_data), .ts_err_sticky(d_ts_sticky),
    .ovf_err_sticky(d_ovf_sticky), .late_count(d_late_cnt), .level(d_level),
    .full(d_full), .empty(d_empty)
  );

  rto_core_param #(.DATA_W(DW), .TS_W(TW), .TS_LSB(TL), .DEPTH(DP), .LATE_MODE(1)) u_emit (
    .clk(clk), .reset(reset), .auto_start(auto_start), .flush(flush), .write(write),
    .din(din), .counter(counter), .error_clear(error_clear),
    .rto_out(e_rto_out), .rto_valid(e_valid), .timestamp_error(e_ts_err),
    .timestamp_error_data(e_ts_data), .overflow_error(e_ovf_err),
    .overflow_error_data(e_ovf_data), .ts_err_sticky(e_ts_sticky),
    .ovf_err_sticky(e_ovf_sticky), .late_count(e_late_cnt), .level(e_level),
    .full(e_full), .empty(e_empty)
  );

  function automatic logic [DW-1:0] mk(input logic [15:0] p, input logic [15:0] ts);
    return {p, ts, 8'hA5};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; auto_start = 1'b0; flush = 1'b0; write = 1'b0;
    din = '0; counter = '0; error_clear = 1'b0;
    step(); step();
    checks++;
    if ({d_rto_out, d_ts_data, d_ovf_data, d_valid, d_ts_err, d_ovf_err, d_ts_sticky,
         d_ovf_sticky, d_full, d_late_cnt, d_level} !== '0) begin
      errors++; $display("[TB] FAIL reset_drop_outputs rto_out=%h level=%0d not all zero", d_rto_out, d_level);
    end
    checks++;
    if ({e_rto_out, e_ts_data, e_ovf_data, e_valid, e_ts_err, e_ovf_err, e_ts_sticky,
         e_ovf_sticky, e_full, e_late_cnt, e_level} !== '0) begin
      errors++; $display("[TB] FAIL reset_emit_outputs rto_out=%h level=%0d not all zero", e_rto_out, e_level);
    end
    checks++;
    if (d_empty !== 1'b1 || e_empty !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_empty got %b/%b exp 1/1", d_empty, e_empty);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_release();
    auto_start = 1'b1;
    counter = 16'd95; write = 1'b1; din = mk(16'h1111, 16'd100);
    step();
    checks++;
    if (d_empty !== 1'b0 || d_level !== 3'd1) begin
      errors++; $display("[TB] FAIL release_first_write empty=%b level=%0d exp 0/1", d_empty, d_level);
    end
    counter = 16'd96; din = mk(16'h2222, 16'd101);
    step();
    write = 1'b0;
    for (int c = 97; c <= 99; c++) begin
      counter = 16'(c);
      step();
      checks++;
      if (d_valid !== 1'b0 || e_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL release_early_valid counter=%0d got %b/%b exp 0", c, d_valid, e_valid);
      end
    end
    counter = 16'd100;
    step();
    checks++;
    if (d_valid !== 1'b1 || d_rto_out !== mk(16'h1111, 16'd100)) begin
      errors++; $display("[TB] FAIL release_ts100 valid=%b out=%h exp 1/%h", d_valid, d_rto_out, mk(16'h1111, 16'd100));
    end
    counter = 16'd101;
    step();
    checks++;
    if (d_valid !== 1'b1 || d_rto_out !== mk(16'h2222, 16'd101) ||
        e_valid !== 1'b1 || e_rto_out !== mk(16'h2222, 16'd101)) begin
      errors++; $display("[TB] FAIL release_ts101 valid=%b/%b out=%h/%h exp %h", d_valid, e_valid, d_rto_out, e_rto_out, mk(16'h2222, 16'd101));
    end
    counter = 16'd102;
    step();
    checks++;
    if (d_valid !== 1'b0 || d_empty !== 1'b1 || d_ts_sticky !== 1'b0 || e_ts_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL release_after valid=%b empty=%b sticky=%b/%b exp 0/1/0/0", d_valid, d_empty, d_ts_sticky, e_ts_sticky);
    end
  endtask

  task automatic test_late();
    counter = 16'd60; write = 1'b1; din = mk(16'h5050, 16'd50);
    step();
    write = 1'b0;
    step();
    checks++;
    if (d_ts_err !== 1'b1 || d_ts_data !== mk(16'h5050, 16'd50) || d_late_cnt !== 16'd1 ||
        d_ts_sticky !== 1'b1 || d_valid !== 1'b0 || d_empty !== 1'b1) begin
      errors++; $display("[TB] FAIL late_drop err=%b data=%h cnt=%0d sticky=%b valid=%b empty=%b exp 1/%h/1/1/0/1",
                         d_ts_err, d_ts_data, d_late_cnt, d_ts_sticky, d_valid, d_empty, mk(16'h5050, 16'd50));
    end
    checks++;
    if (e_ts_err !== 1'b1 || e_valid !== 1'b1 || e_rto_out !== mk(16'h5050, 16'd50) || e_late_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL late_emit err=%b valid=%b out=%h cnt=%0d exp 1/1/%h/1", e_ts_err, e_valid, e_rto_out, e_late_cnt, mk(16'h5050, 16'd50));
    end
    step();
    checks++;
    if (d_ts_err !== 1'b0 || e_ts_err !== 1'b0 || d_rto_out !== mk(16'h2222, 16'd101)) begin
      errors++; $display("[TB] FAIL late_pulse_end err=%b/%b drop_out=%h exp 0/0/%h", d_ts_err, e_ts_err, d_rto_out, mk(16'h2222, 16'd101));
    end
  endtask

  task automatic test_overflow_wrap();
    logic [15:0] ts;
    for (int r = 0; r < 3; r++) begin
      auto_start = 1'b0; counter = '0;
      for (int i = 0; i < 4; i++) begin
        write = 1'b1; din = mk(16'h1000 + 16'(r * 16 + i), 16'(200 + r * 10 + i));
        step();
        checks++;
        if (d_level !== 3'(i + 1)) begin
          errors++; $display("[TB] FAIL wrap_level r=%0d i=%0d got %0d exp %0d", r, i, d_level, i + 1);
        end
      end
      if (r == 0) begin
        checks++;
        if (d_full !== 1'b1 || e_full !== 1'b1) begin
          errors++; $display("[TB] FAIL ovf_full got %b/%b exp 1", d_full, e_full);
        end
        din = mk(16'hDEAD, 16'd204);
        step();
        checks++;
        if (d_ovf_err !== 1'b1 || d_ovf_data !== mk(16'hDEAD, 16'd204) || d_ovf_sticky !== 1'b1 ||
            d_level !== 3'd4 || e_ovf_err !== 1'b1 || e_ovf_data !== mk(16'hDEAD, 16'd204)) begin
          errors++; $display("[TB] FAIL ovf_pulse err=%b data=%h sticky=%b level=%0d exp 1/%h/1/4", d_ovf_err, d_ovf_data, d_ovf_sticky, d_level, mk(16'hDEAD, 16'd204));
        end
        write = 1'b0;
        step();
        checks++;
        if (d_ovf_err !== 1'b0 || e_ovf_sticky !== 1'b1) begin
          errors++; $display("[TB] FAIL ovf_pulse_end err=%b sticky=%b exp 0/1", d_ovf_err, e_ovf_sticky);
        end
      end
      write = 1'b0;
      auto_start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        ts = 16'(200 + r * 10 + i);
        counter = ts;
        step();
        checks++;
        if (d_valid !== 1'b1 || d_rto_out !== mk(16'h1000 + 16'(r * 16 + i), ts)) begin
          errors++; $display("[TB] FAIL wrap_order r=%0d i=%0d valid=%b out=%h exp 1/%h", r, i, d_valid, d_rto_out, mk(16'h1000 + 16'(r * 16 + i), ts));
        end
      end
      checks++;
      if (d_empty !== 1'b1 || d_ts_err !== 1'b0) begin
        errors++; $display("[TB] FAIL wrap_drain r=%0d empty=%b ts_err=%b exp 1/0", r, d_empty, d_ts_err);
      end
    end
  endtask

  task automatic test_flush_clear();
    auto_start = 1'b0; counter = '0;
    for (int i = 0; i < 3; i++) begin
      write = 1'b1; din = mk(16'h3000 + 16'(i), 16'(300 + i));
      step();
    end
    checks++;
    if (d_level !== 3'd3) begin
      errors++; $display("[TB] FAIL flush_fill level got %0d exp 3", d_level);
    end
    flush = 1'b1; din = mk(16'hBEEF, 16'd300);
    step();
    flush = 1'b0; write = 1'b0;
    checks++;
    if (d_empty !== 1'b1 || d_level !== 3'd0 || d_ovf_err !== 1'b0 || e_ovf_err !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_empty empty=%b level=%0d ovf=%b/%b exp 1/0/0/0", d_empty, d_level, d_ovf_err, e_ovf_err);
    end
    checks++;
    if (d_ovf_sticky !== 1'b1 || d_late_cnt !== 16'd1 || d_ovf_data !== mk(16'hDEAD, 16'd204)) begin
      errors++; $display("[TB] FAIL flush_retain sticky=%b cnt=%0d ovf_data=%h exp 1/1/%h", d_ovf_sticky, d_late_cnt, d_ovf_data, mk(16'hDEAD, 16'd204));
    end
    auto_start = 1'b1; counter = 16'd20; write = 1'b1; din = mk(16'h0A0A, 16'd10);
    step();
    write = 1'b0; error_clear = 1'b1;
    step();
    checks++;
    if (d_ts_sticky !== 1'b1 || d_late_cnt !== 16'd1 || d_ovf_sticky !== 1'b0 || d_ts_err !== 1'b1) begin
      errors++; $display("[TB] FAIL clear_vs_late sticky=%b cnt=%0d ovf_sticky=%b err=%b exp 1/1/0/1", d_ts_sticky, d_late_cnt, d_ovf_sticky, d_ts_err);
    end
    step();
    error_clear = 1'b0;
    checks++;
    if (d_ts_sticky !== 1'b0 || d_late_cnt !== 16'd0 || e_late_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL clear_only sticky=%b cnt=%0d/%0d exp 0/0/0", d_ts_sticky, d_late_cnt, e_late_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    auto_start = 1'b1; counter = '0; write = 1'b1; din = mk(16'h5555, 16'd500);
    step();
    write = 1'b0; counter = 16'd500; reset = 1'b1;
    step();
    checks++;
    if (d_valid !== 1'b0 || e_valid !== 1'b0 || d_empty !== 1'b1 || d_level !== 3'd0 ||
        d_rto_out !== '0 || d_ts_data !== '0 || d_ovf_data !== '0) begin
      errors++; $display("[TB] FAIL reset_mid valid=%b/%b empty=%b level=%0d out=%h exp 0/0/1/0/0", d_valid, e_valid, d_empty, d_level, d_rto_out);
    end
    reset = 1'b0;
    step();
    checks++;
    if (d_valid !== 1'b0 || e_valid !== 1'b0 || e_empty !== 1'b1 || d_ts_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_after valid=%b/%b empty=%b ts_err=%b exp 0/0/1/0", d_valid, e_valid, e_empty, d_ts_err);
    end
  endtask

  initial begin
    $display("[TB] starting rto_core_param bench");
    test_reset();
    test_release();
    test_late();
    test_overflow_wrap();
    test_flush_clear();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
